// File: rtl/dvp_cam_emulator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dvp_cam_emulator_if : DVP camera bus (pclk, vsync, href, data) to capture side
// Rev 1.0
// ----------------------------------------------------------------------------
interface dvp_cam_emulator_if;
   logic       pclk_out;
   logic       vsync_out;
   logic       href_out;
   logic [7:0] data_out;

   modport master (output pclk_out, vsync_out, href_out, data_out);
   modport slave  (input  pclk_out, vsync_out, href_out, data_out);
endinterface
`default_nettype wire

// File: rtl/dvp_cam_emulator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dvp_cam_emulator : OV7670-style DVP RGB565 test-pattern source, CAM_EMU_CRC_EN adds frame CRC
// Rev 1.0
// ----------------------------------------------------------------------------
module dvp_cam_emulator #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 144,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 17,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int PCLK_DIV = 4
) (
   input  logic               CLK100MHZ,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [1:0]         pattern_sel,
   dvp_cam_emulator_if.master dvp,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic               busy
`ifdef CAM_EMU_CRC_EN
   ,
   output logic [15:0]        frame_crc,
   output logic               crc_valid
`endif
);

   localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
   localparam int HALF  = PCLK_DIV / 2;
   localparam int VM_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
   localparam int VM_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int V_MAX = (VM_A > VM_B) ? VM_A : VM_B;
   localparam int DW    = $clog2(PCLK_DIV);
   localparam int HW    = $clog2(LINE + 1);
   localparam int VW    = $clog2(V_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBACK  = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFRONT = 3'd4
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_div, w_div_nxt;
   logic [HW-1:0]   r_hcnt;
   logic [VW-1:0]   r_vcnt;
   logic [1:0]      r_pat;
   logic            r_pclk, r_vsync, r_href;
   logic [7:0]      r_data;
   logic [15:0]     r_frame_count;

   logic            w_tick, w_fall, w_line_end, w_last_line, w_state_end, w_vsync_entry;
   logic            w_href_nxt, w_ybit3;
   logic [15:0]     w_x, w_bar_rgb, w_pix;
   logic [2:0]      w_bar;
   logic [7:0]      w_byte;

   // w_tick closes a pclk period; w_fall is the edge where pclk drops and outputs move
   assign w_tick        = (r_state != S_IDLE) && (r_div == DW'(PCLK_DIV - 1));
   assign w_fall        = (r_state != S_IDLE) && (r_div == DW'(HALF - 1));
   assign w_line_end    = w_tick && (r_hcnt == HW'(LINE - 1));
   assign w_state_end   = w_line_end && w_last_line;
   assign w_vsync_entry = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);
   assign w_div_nxt     = ((r_state == S_IDLE) || w_tick) ? '0 : r_div + DW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_last_line = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) w_state_nxt = S_VSYNC;
         end
         S_VSYNC: begin
            w_last_line = (r_vcnt == VW'(V_SYNC - 1));
            if (w_line_end && w_last_line) w_state_nxt = S_VBACK;
         end
         S_VBACK: begin
            w_last_line = (r_vcnt == VW'(V_BACK - 1));
            if (w_line_end && w_last_line) w_state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            w_last_line = (r_vcnt == VW'(V_ACTIVE - 1));
            if (w_line_end && w_last_line) w_state_nxt = S_VFRONT;
         end
         S_VFRONT: begin
            w_last_line = (r_vcnt == VW'(V_FRONT - 1));
            if (w_line_end && w_last_line) w_state_nxt = enable ? S_VSYNC : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Pixel generation for the byte that goes out on the coming falling edge
   assign w_href_nxt = (r_state == S_ACTIVE) && (r_hcnt < HW'(2 * H_ACTIVE));
   assign w_x        = 16'(r_hcnt >> 1);
   assign w_ybit3    = ((32'(r_vcnt) >> 3) & 32'd1) != 32'd0;
   assign w_bar      = 3'((32'(w_x) * 32'd8) / 32'(H_ACTIVE));

   always_comb begin
      w_bar_rgb = 16'h0000;
      case (w_bar)
         3'd0: w_bar_rgb = 16'hFFFF;
         3'd1: w_bar_rgb = 16'hFFE0;
         3'd2: w_bar_rgb = 16'h07FF;
         3'd3: w_bar_rgb = 16'h07E0;
         3'd4: w_bar_rgb = 16'hF81F;
         3'd5: w_bar_rgb = 16'hF800;
         3'd6: w_bar_rgb = 16'h001F;
         default: w_bar_rgb = 16'h0000;
      endcase
   end

   always_comb begin
      w_pix = 16'h0000;
      case (r_pat)
         2'd0: w_pix = w_bar_rgb;
         2'd1: w_pix = {w_x[4:0], w_x[5:0], w_x[4:0]};
         2'd2: w_pix = r_frame_count;
         default: w_pix = (w_x[3] ^ w_ybit3) ? 16'hFFFF : 16'h0000;
      endcase
   end

   assign w_byte = r_hcnt[0] ? w_pix[7:0] : w_pix[15:8];

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         r_div         <= '0;
         r_hcnt        <= '0;
         r_vcnt        <= '0;
         r_pat         <= 2'd0;
         r_pclk        <= 1'b0;
         r_vsync       <= 1'b0;
         r_href        <= 1'b0;
         r_data        <= 8'h00;
         r_frame_count <= 16'h0000;
      end else begin
         r_div  <= w_div_nxt;
         r_pclk <= (w_state_nxt != S_IDLE) && (w_div_nxt < DW'(HALF));
         if ((r_state == S_IDLE) || w_line_end) r_hcnt <= '0;
         else if (w_tick)                       r_hcnt <= r_hcnt + HW'(1);
         if ((r_state == S_IDLE) || w_state_end) r_vcnt <= '0;
         else if (w_line_end)                    r_vcnt <= r_vcnt + VW'(1);
         if (w_vsync_entry) r_pat <= pattern_sel;
         if (w_fall) begin
            r_vsync <= (r_state == S_VSYNC);
            r_href  <= w_href_nxt;
            r_data  <= w_href_nxt ? w_byte : 8'h00;
         end
         if (frame_done) r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign frame_done    = w_state_end && (r_state == S_VFRONT);
   assign frame_count   = r_frame_count;
   assign busy          = (r_state != S_IDLE);
   assign dvp.pclk_out  = r_pclk;
   assign dvp.vsync_out = r_vsync;
   assign dvp.href_out  = r_href;
   assign dvp.data_out  = r_data;

`ifdef CAM_EMU_CRC_EN
   function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   logic [15:0] r_crc, r_frame_crc;

   // Running CRC is final well before VFRONT, so it can be presented during the pulse
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         r_crc       <= 16'h0000;
         r_frame_crc <= 16'h0000;
      end else begin
         if (w_vsync_entry)            r_crc <= 16'hFFFF;
         else if (w_fall && w_href_nxt) r_crc <= f_crc_byte(r_crc, w_byte);
         if (frame_done) r_frame_crc <= r_crc;
      end
   end

   assign crc_valid = frame_done;
   assign frame_crc = frame_done ? r_crc : r_frame_crc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvp_cam_emulator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dvp_cam_emulator : directed/randomized frame checks against a pixel-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dvp_cam_emulator;

   localparam int H_ACTIVE    = 8;
   localparam int H_BLANK     = 2;
   localparam int V_SYNC      = 1;
   localparam int V_BACK      = 1;
   localparam int V_ACTIVE    = 10;
   localparam int V_FRONT     = 1;
   localparam int PCLK_DIV    = 4;
   localparam int LINE        = 2 * H_ACTIVE + H_BLANK;
   localparam int FRAME_CLKS  = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * LINE * PCLK_DIV;
   localparam int ACT_START   = (V_SYNC + V_BACK) * LINE * PCLK_DIV;
   localparam int ACT_END     = (V_SYNC + V_BACK + V_ACTIVE) * LINE * PCLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        busy;
`ifdef CAM_EMU_CRC_EN
   logic [15:0] frame_crc;
   logic        crc_valid;
`endif

   dvp_cam_emulator_if dvp_bus ();

   dvp_cam_emulator #(
      .H_ACTIVE (H_ACTIVE), .H_BLANK (H_BLANK), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
      .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .PCLK_DIV (PCLK_DIV)
   ) dut (
      .CLK100MHZ   (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .dvp         (dvp_bus),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .busy        (busy)
`ifdef CAM_EMU_CRC_EN
      ,
      .frame_crc   (frame_crc),
      .crc_valid   (crc_valid)
`endif
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Receiver model: samples on pclk rising edges, like the capture block would
   logic       prev_pclk, prev_vs, prev_href, prev_href_s;
   logic [7:0] prev_data;
   int         mon_vs, mon_pulses, mon_viol, mon_frames;
   int         last_vs, last_pulses, last_viol;
   logic [7:0] mon_q[$];
   logic [7:0] last_q[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_vs = 0; mon_pulses = 0; mon_viol = 0; mon_frames = 0;
         last_vs = 0; last_pulses = 0; last_viol = 0;
         mon_q.delete(); last_q.delete();
         prev_href_s = 1'b0;
      end else begin
         if ({dvp_bus.vsync_out, dvp_bus.href_out, dvp_bus.data_out} !== {prev_vs, prev_href, prev_data}
             && !(prev_pclk && !dvp_bus.pclk_out))
            mon_viol++;
         if (dvp_bus.pclk_out && !prev_pclk) begin
            if (dvp_bus.vsync_out) mon_vs++;
            if (dvp_bus.href_out) begin
               mon_q.push_back(dvp_bus.data_out);
               if (!prev_href_s) mon_pulses++;
            end else if (dvp_bus.data_out !== 8'h00) begin
               mon_viol++;
            end
            prev_href_s = dvp_bus.href_out;
         end
         if (frame_done) begin
            last_vs = mon_vs; last_pulses = mon_pulses; last_viol = mon_viol; last_q = mon_q;
            mon_vs = 0; mon_pulses = 0; mon_viol = 0; mon_q.delete();
            mon_frames++;
         end
      end
      prev_pclk = dvp_bus.pclk_out;
      prev_vs   = dvp_bus.vsync_out;
      prev_href = dvp_bus.href_out;
      prev_data = dvp_bus.data_out;
   end

   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   logic [7:0]  bar_line0 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                   8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
   logic [7:0]  exp_q[$];
   logic [15:0] exp_crc;

   function automatic logic [15:0] model_pix(input int pat, input int x, input int y, input int fc);
      case (pat)
         0:       return bars[(x * 8) / H_ACTIVE];
         1:       return 16'(((x % 32) * 2048) + ((x % 64) * 32) + (x % 32));
         2:       return 16'(fc);
         default: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   task automatic build_expected(input int pat, input int fc);
      logic [15:0] p;
      logic [7:0]  b;
      exp_q.delete();
      exp_crc = 16'hFFFF;
      for (int y = 0; y < V_ACTIVE; y++) begin
         for (int x = 0; x < H_ACTIVE; x++) begin
            p = model_pix(pat, x, y, fc);
            for (int h = 0; h < 2; h++) begin
               b = (h == 0) ? p[15:8] : p[7:0];
               exp_q.push_back(b);
               for (int i = 7; i >= 0; i--) begin
                  if (exp_crc[15] != b[i]) exp_crc = 16'((exp_crc * 2) ^ 16'h1021);
                  else                     exp_crc = 16'(exp_crc * 2);
               end
            end
         end
      end
   endtask

   // mode: 0 keep streaming, 1 drop then reassert in VFRONT, 2 drop and stop
   task automatic run_frame(input int n, input int pat, input int pat_next, input int mode, input int start);
      int cycles;
      int k;
      bit seen;
      cycles = start;
      seen   = 1'b0;
      k      = $urandom_range(ACT_END - 8, ACT_START + 8);
      build_expected(pat, n);
      while (!seen && cycles < FRAME_CLKS + 64) begin
         @(posedge clk); #1;
         cycles++;
         if (cycles == k) begin
            pattern_sel = 2'(pat_next);
            if (mode != 0) enable = 1'b0;
         end
         if (mode == 1 && cycles == FRAME_CLKS - 20) enable = 1'b1;
         if (frame_done) seen = 1'b1;
      end
      chk("frame_done_seen", 32'(seen), 32'd1);
      chk("frame_clocks", cycles, FRAME_CLKS);
      chk("count_during_done", 32'(frame_count), n);
`ifdef CAM_EMU_CRC_EN
      chk("crc_valid_with_done", 32'(crc_valid), 32'(frame_done));
      chk("frame_crc", 32'(frame_crc), 32'(exp_crc));
`endif
      @(posedge clk); #1;
      chk("frame_done_width", 32'(frame_done), 32'd0);
      chk("count_after_done", 32'(frame_count), n + 1);
      chk("busy_after_done", 32'(busy), (mode == 2) ? 32'd0 : 32'd1);
      chk("vsync_periods", last_vs, V_SYNC * LINE);
      chk("href_pulses", last_pulses, V_ACTIVE);
      chk("edge_violations", last_viol, 0);
      chk("href_bytes", last_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < last_q.size(); i++)
         chk($sformatf("f%0d_byte%0d", n, i), 32'(last_q[i]), 32'(exp_q[i]));
      if (pat == 0)
         for (int i = 0; i < 16 && i < last_q.size(); i++)
            chk($sformatf("bar_line0_byte%0d", i), 32'(last_q[i]), 32'(bar_line0[i]));
`ifdef CAM_EMU_CRC_EN
      chk("crc_valid_drop", 32'(crc_valid), 32'd0);
      chk("frame_crc_hold", 32'(frame_crc), 32'(exp_crc));
`endif
   endtask

   int pats [7];
   bit idle_activity;

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      repeat (4) @(posedge clk);
      #1;
      chk("reset_outputs", {dvp_bus.pclk_out, dvp_bus.vsync_out, dvp_bus.href_out, dvp_bus.data_out,
                            frame_done, frame_count, busy}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         chk("idle_outputs", {dvp_bus.pclk_out, dvp_bus.vsync_out, dvp_bus.href_out, dvp_bus.data_out,
                              frame_done, frame_count, busy}, 32'd0);
      end
`ifdef CAM_EMU_CRC_EN
      chk("crc_reset", {15'd0, crc_valid, frame_crc}, 32'd0);
`endif

      pats = '{0, 2, 2, 2, 3, 1, int'($urandom_range(3, 0))};
      pattern_sel = 2'(pats[0]);
      enable      = 1'b1;
      @(posedge clk); #1;
      chk("busy_on_start", 32'(busy), 32'd1);
      for (int n = 0; n < 7; n++)
         run_frame(n, pats[n], (n < 6) ? pats[n + 1] : int'($urandom_range(3, 0)),
                   (n == 6) ? 2 : ((n == 3) ? 1 : 0), 1);

      idle_activity = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         @(posedge clk); #1;
         if (dvp_bus.pclk_out || dvp_bus.vsync_out || dvp_bus.href_out || busy || frame_done)
            idle_activity = 1'b1;
      end
      chk("quiet_after_stop", 32'(idle_activity), 32'd0);
      chk("final_frame_count", 32'(frame_count), 32'd7);
      chk("monitor_frames", mon_frames, 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
